// File: rtl/bin_bcd_secuencial_pkg.sv
// ---------------------------------------------------------------------------
// bin_bcd_secuencial_pkg
// Shared constants for the sequential binary-to-BCD converter:
//   - FSM state encoding (REPOSO / DESPLAZA / FIN)
//   - BCD nibble width
//   - double-dabble add-3 threshold and increment
// ---------------------------------------------------------------------------
package bin_bcd_secuencial_pkg;

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] DESPLAZA = 2'd1;
    localparam logic [1:0] FIN      = 2'd2;

    localparam int         NIBBLE   = 4;
    localparam int         DIGITOS  = 4;

    localparam logic [NIBBLE-1:0] UMBRAL = 4'd5;
    localparam logic [NIBBLE-1:0] SUMA   = 4'd3;

endpackage

// File: rtl/bin_bcd_secuencial_ajuste_bcd.sv
// ---------------------------------------------------------------------------
// ajuste_bcd
// Combinational double-dabble correction cell: a nibble of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   i_nibble  in  4  BCD nibble before correction
//   o_nibble  out 4  corrected nibble
// ---------------------------------------------------------------------------
module ajuste_bcd
    import bin_bcd_secuencial_pkg::*;
(
    input  logic [NIBBLE-1:0] i_nibble,
    output logic [NIBBLE-1:0] o_nibble
);

    assign o_nibble = (i_nibble >= UMBRAL) ? (i_nibble + SUMA) : i_nibble;

endmodule

// File: rtl/bin_bcd_secuencial.sv
// ---------------------------------------------------------------------------
// bin_bcd_secuencial
// Multi-cycle binary-to-BCD converter (shift-and-add-3). A start strobe in
// REPOSO captures numero (saturated to MAXIMO), ANCHO shift cycles build the
// BCD value, and a FIN cycle copies it to the registered digit outputs.
// Digits and desborde only change at FIN or reset.
//
// Handshake: iniciar is a request that is accepted on a rising edge only
// while ocupado=0 (state REPOSO); requests while ocupado=1 are dropped.
// listo is a registered one-cycle pulse marking new digits; there is no
// back-pressure, the consumer must take the digits or rely on them staying
// stable until the next listo.
//
// Ports:
//   clock     in   1      system clock, rising edge
//   reset     in   1      synchronous active-high reset
//   numero    in   ANCHO  unsigned value, sampled on accepted iniciar
//   iniciar   in   1      start strobe
//   ocupado   out  1      conversion in progress (state != REPOSO)
//   listo     out  1      one-cycle pulse, new digits valid
//   desborde  out  1      last converted value exceeded MAXIMO
//   miles     out  4      thousands digit
//   centenas  out  4      hundreds digit
//   decenas   out  4      tens digit
//   unidades  out  4      units digit
//   o_estado  out  2      FSM state, debug visibility
// ---------------------------------------------------------------------------
module bin_bcd_secuencial
    import bin_bcd_secuencial_pkg::*;
#(
    parameter int ANCHO  = 16,
    parameter int MAXIMO = 9999
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ANCHO-1:0] numero,
    input  logic             iniciar,
    output logic             ocupado,
    output logic             listo,
    output logic             desborde,
    output logic [3:0]       miles,
    output logic [3:0]       centenas,
    output logic [3:0]       decenas,
    output logic [3:0]       unidades,
    output logic [1:0]       o_estado
);

    localparam int               BCD_W = NIBBLE * DIGITOS;
    localparam int               CNT_W = (ANCHO > 1) ? $clog2(ANCHO) : 1;
    localparam logic [ANCHO-1:0] MAX_V = ANCHO'(MAXIMO);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(ANCHO - 1);

    logic [1:0]       r_estado;
    logic [ANCHO-1:0] r_shift;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_desb_int;
    logic             r_listo;
    logic             r_desborde;
    logic [3:0]       r_miles;
    logic [3:0]       r_centenas;
    logic [3:0]       r_decenas;
    logic [3:0]       r_unidades;

    // Accumulator after the per-nibble add-3 correction, before the shift.
    logic [BCD_W-1:0] w_adj;

    for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
        ajuste_bcd u_ajuste (
            .i_nibble (r_bcd[g*NIBBLE +: NIBBLE]),
            .o_nibble (w_adj[g*NIBBLE +: NIBBLE])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= REPOSO;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_desb_int <= 1'b0;
            r_listo    <= 1'b0;
            r_desborde <= 1'b0;
            r_miles    <= 4'd0;
            r_centenas <= 4'd0;
            r_decenas  <= 4'd0;
            r_unidades <= 4'd0;
        end else begin
            r_listo <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (iniciar) begin
                        if (numero > MAX_V) begin
                            r_shift    <= MAX_V;
                            r_desb_int <= 1'b1;
                        end else begin
                            r_shift    <= numero;
                            r_desb_int <= 1'b0;
                        end
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_estado <= DESPLAZA;
                    end
                end
                DESPLAZA: begin
                    // {bcd, shift} moves left as one long register.
                    r_bcd   <= {w_adj[BCD_W-2:0], r_shift[ANCHO-1]};
                    r_shift <= {r_shift[ANCHO-2:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == ULTIMO) begin
                        r_estado <= FIN;
                    end
                end
                FIN: begin
                    r_miles    <= r_bcd[15:12];
                    r_centenas <= r_bcd[11:8];
                    r_decenas  <= r_bcd[7:4];
                    r_unidades <= r_bcd[3:0];
                    r_desborde <= r_desb_int;
                    r_listo    <= 1'b1;
                    r_estado   <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    assign ocupado  = (r_estado != REPOSO);
    assign listo    = r_listo;
    assign desborde = r_desborde;
    assign miles    = r_miles;
    assign centenas = r_centenas;
    assign decenas  = r_decenas;
    assign unidades = r_unidades;
    assign o_estado = r_estado;

endmodule

// File: tb/tb_bin_bcd_secuencial.sv
// ---------------------------------------------------------------------------
// tb_bin_bcd_secuencial
// Self-checking bench for bin_bcd_secuencial. A cycle-level model computes
// the expected outputs from decimal arithmetic; a compare process checks
// them every cycle, and directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_bin_bcd_secuencial;

    logic        clock;
    logic        reset;
    logic [15:0] numero;
    logic        iniciar;
    logic        ocupado;
    logic        listo;
    logic        desborde;
    logic [3:0]  miles;
    logic [3:0]  centenas;
    logic [3:0]  decenas;
    logic [3:0]  unidades;
    logic [1:0]  estado;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    bin_bcd_secuencial #(.ANCHO(16), .MAXIMO(9999)) dut (
        .clock    (clock),
        .reset    (reset),
        .numero   (numero),
        .iniciar  (iniciar),
        .ocupado  (ocupado),
        .listo    (listo),
        .desborde (desborde),
        .miles    (miles),
        .centenas (centenas),
        .decenas  (decenas),
        .unidades (unidades),
        .o_estado (estado)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // Conversion takes 17 edges after acceptance; result appears with listo.
    int          m_left = 0;
    int          m_val  = 0;
    bit          m_ovf  = 0;
    bit          e_listo = 0;
    bit          e_ocup  = 0;
    bit          e_desb  = 0;
    logic [15:0] e_dig   = 16'h0000;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            m_left  = 0;
            e_listo = 0;
            e_ocup  = 0;
            e_desb  = 0;
            e_dig   = 16'h0000;
        end else begin
            e_listo = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_listo = 1;
                    e_dig   = to_bcd(m_val);
                    e_desb  = m_ovf;
                end
            end else if (iniciar) begin
                m_ovf  = (int'(numero) > 9999);
                m_val  = m_ovf ? 9999 : int'(numero);
                m_left = 17;
            end
            e_ocup = (m_left > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            check("listo",    int'(listo),    int'(e_listo));
            check("ocupado",  int'(ocupado),  int'(e_ocup));
            check("desborde", int'(desborde), int'(e_desb));
            check("digits",   int'({miles, centenas, decenas, unidades}), int'(e_dig));
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the negedge where listo is seen, or flags a timeout.
    task automatic wait_listo(output bit ok, output int busy);
        ok   = 0;
        busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (listo) begin
                ok = 1;
                break;
            end
            if (ocupado) busy++;
            @(negedge clock);
        end
        if (!ok) check("listo_timeout", 0, 1);
    endtask

    task automatic start(input logic [15:0] n, output int acc);
        @(negedge clock);
        numero  = n;
        iniciar = 1'b1;
        @(posedge clock);
        #1 acc = cyc;
        @(negedge clock);
        iniciar = 1'b0;
        numero  = 16'($urandom);
    endtask

    task automatic run(input logic [15:0] n, output int lat, output int busy);
        int acc;
        bit ok;
        start(n, acc);
        wait_listo(ok, busy);
        lat = ok ? (cyc - acc) : -1;
    endtask

    task automatic count_listo(input int ncyc, output int cnt);
        cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            if (listo) cnt++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    logic [15:0] vals  [4] = '{16'd0, 16'd9999, 16'd10000, 16'd65535};
    logic [15:0] edig  [4] = '{16'h0000, 16'h9999, 16'h9999, 16'h9999};
    bit          eovf  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int lat, busy, acc, cnt, prev;
        bit ok;
        logic [15:0] want;

        reset   = 1'b1;
        iniciar = 1'b0;
        numero  = 16'd0;
        @(posedge clock);
        #1 chk_en = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_digits",  int'({miles, centenas, decenas, unidades}), 0);
        reset = 1'b0;

        // 1234: latency, busy time, digits
        run(16'd1234, lat, busy);
        check("lat_1234",  lat, 17);
        check("busy_1234", busy, 17);
        check("dig_1234",  int'({miles, centenas, decenas, unidades}), 16'h1234);
        check("ovf_1234",  int'(desborde), 0);

        // boundaries and saturation
        for (int i = 0; i < 4; i++) begin
            run(vals[i], lat, busy);
            check("dig_bound", int'({miles, centenas, decenas, unidades}), int'(edig[i]));
            check("ovf_bound", int'(desborde), int'(eovf[i]));
        end

        // request while busy is ignored
        start(16'd42, acc);
        repeat (4) @(negedge clock);
        numero  = 16'd7777;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        wait_listo(ok, busy);
        check("dig_42", int'({miles, centenas, decenas, unidades}), 16'h0042);
        count_listo(25, cnt);
        check("listo_once_42", cnt, 0);

        // reset mid-conversion
        run(16'd5555, lat, busy);
        check("dig_5555", int'({miles, centenas, decenas, unidades}), 16'h5555);
        start(16'd8888, acc);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_ocupado",  int'(ocupado), 0);
        check("abort_listo",    int'(listo), 0);
        check("abort_desborde", int'(desborde), 0);
        check("abort_digits",   int'({miles, centenas, decenas, unidades}), 0);
        reset = 1'b0;
        count_listo(30, cnt);
        check("abort_no_listo", cnt, 0);

        // back-to-back with iniciar held high
        @(negedge clock);
        numero  = 16'd305;
        iniciar = 1'b1;
        prev    = -1;
        want    = 16'h0305;
        for (int p = 0; p < 4; p++) begin
            @(negedge clock);
            wait_listo(ok, busy);
            if (!ok) break;
            check("b2b_digits", int'({miles, centenas, decenas, unidades}), int'(want));
            if (prev >= 0) check("b2b_period", cyc - prev, 18);
            prev = cyc;
            numero = (numero == 16'd305) ? 16'd9000 : 16'd305;
            want   = (want == 16'h0305) ? 16'h9000 : 16'h0305;
        end
        iniciar = 1'b0;
        repeat (20) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
